zbus_iomaster: RTL and testbench

- ZX-bus I/O cycle initiator for the CPLD bench and the host-side controller.
- Takes one read or write command at a time and generates a Z80-timed I/O cycle on za/zd/ziorq_n/zrd_n/zwr_n: T1, T2, automatic TW, optional extra TWs, then T3.
- This is the counterpart of the port-decoding responder. It drives the cycles that responder decodes, and returns read data and an ziorqge-claim flag.

---
 rtl/zbus_pkg.sv | 18 +
 rtl/zbus_tstate_ctr.sv | 31 +++
 rtl/zbus_iomaster.sv | 149 ++++++++++++++
 tb/tb_zbus_iomaster.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/zbus_pkg.sv
// Shared ZX-bus definitions: cycle states, wait counter width, responder base
// address and the T-state divider legality check.
package zbus_pkg;

  typedef enum logic [2:0] {IDLE, T1, T2, TW, T3} zstate_t;

  // Width of the extra-wait counter; WAIT_MAX must fit in it.
  localparam int WAIT_W = 4;

  // Low address byte the port-decoding responder answers to.
  localparam logic [7:0] BASE_ADDR = 8'hAB;

  // A T-state needs a midpoint, so the divider must be even and at least 2.
  function automatic bit tdiv_ok(input int tdiv);
    return (tdiv >= 2) && ((tdiv % 2) == 0);
  endfunction

endpackage

// File: rtl/zbus_tstate_ctr.sv
// T-state phase counter: counts fclk cycles 0..TDIV-1 inside each bus state
// and flags the last and middle cycle of the T-state.
module zbus_tstate_ctr #(
  parameter int TDIV = 4,
  parameter int CW   = $clog2(TDIV)
) (
  input  logic          fclk,
  input  logic          zrst_n,
  input  logic          run,
  output logic [CW-1:0] tcnt,
  output logic          last,
  output logic          mid
);

  localparam logic [CW-1:0] LAST_V = CW'(TDIV - 1);
  localparam logic [CW-1:0] MID_V  = CW'(TDIV / 2 - 1);

  assign last = (tcnt == LAST_V);
  assign mid  = (tcnt == MID_V);

  // Held at 0 while idle so the first T1 cycle after accept starts at 0.
  always_ff @(posedge fclk or negedge zrst_n) begin
    if (!zrst_n)
      tcnt <= '0;
    else if (!run || last)
      tcnt <= '0;
    else
      tcnt <= tcnt + CW'(1);
  end

endmodule

// File: rtl/zbus_iomaster.sv
// ZX-bus I/O cycle initiator: runs one Z80-timed IN/OUT cycle per command
// (T1, T2, automatic TW, optional extra TWs, T3) and reports read data,
// the ziorqge claim and a wait-timeout error.
module zbus_iomaster
  import zbus_pkg::*;
#(
  parameter int TDIV     = 4,
  parameter int WAIT_MAX = 15
) (
  input  logic        fclk,
  input  logic        zrst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_wr,
  input  logic [15:0] cmd_addr,
  input  logic [7:0]  cmd_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_ge,
  output logic        rsp_err,
  output logic [15:0] za,
  output logic [7:0]  zd_out,
  output logic        zd_oe,
  input  logic [7:0]  zd_in,
  output logic        ziorq_n,
  output logic        zrd_n,
  output logic        zwr_n,
  input  logic        zwait_n,
  input  logic        ziorqge
);

  localparam int CW = $clog2(TDIV);
  localparam logic [CW-1:0]     PRE_LAST_V = CW'(TDIV - 2);
  localparam logic [WAIT_W-1:0] WMAX       = WAIT_W'(WAIT_MAX);

  generate
    if (!tdiv_ok(TDIV)) begin : g_bad_tdiv
      $error("zbus_iomaster: TDIV must be even and >= 2");
    end
    if ((WAIT_MAX < 0) || (WAIT_MAX >= (1 << WAIT_W))) begin : g_bad_wait
      $error("zbus_iomaster: WAIT_MAX does not fit the wait counter");
    end
  endgenerate

  zstate_t           state;
  logic              wr;
  logic [WAIT_W-1:0] wcnt;
  logic [CW-1:0]     tcnt;
  logic              last;
  logic              mid;
  logic              pre_last;

  assign pre_last = (tcnt == PRE_LAST_V);

  zbus_tstate_ctr #(.TDIV(TDIV), .CW(CW)) u_ctr (
    .fclk   (fclk),
    .zrst_n (zrst_n),
    .run    (state != IDLE),
    .tcnt   (tcnt),
    .last   (last),
    .mid    (mid)
  );

  // Bus cycle sequencer; every bus and response output is registered here.
  always_ff @(posedge fclk or negedge zrst_n) begin
    if (!zrst_n) begin
      state     <= IDLE;
      wr        <= 1'b0;
      wcnt      <= '0;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 8'h00;
      rsp_ge    <= 1'b0;
      rsp_err   <= 1'b0;
      za        <= 16'h0000;
      zd_out    <= 8'h00;
      zd_oe     <= 1'b0;
      ziorq_n   <= 1'b1;
      zrd_n     <= 1'b1;
      zwr_n     <= 1'b1;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          zd_oe     <= 1'b0;
          if (cmd_valid && cmd_ready) begin
            // Command is captured here; cmd_* is ignored until back in IDLE.
            cmd_ready <= 1'b0;
            wr        <= cmd_wr;
            za        <= cmd_addr;
            rsp_ge    <= 1'b0;
            rsp_err   <= 1'b0;
            wcnt      <= '0;
            if (cmd_wr) begin
              zd_out <= cmd_wdata;
              zd_oe  <= 1'b1;
            end
            state <= T1;
          end
        end
        T1: begin
          if (last) begin
            ziorq_n <= 1'b0;
            if (wr) zwr_n <= 1'b0;
            else    zrd_n <= 1'b0;
            state <= T2;
          end
        end
        T2: begin
          if (last) begin
            rsp_ge <= ziorqge;
            state  <= TW;
          end
        end
        TW: begin
          // The first TW is automatic; each low zwait_n sample adds one more.
          if (last) begin
            if (zwait_n) begin
              state <= T3;
            end else if (wcnt == WMAX) begin
              rsp_err <= 1'b1;
              state   <= T3;
            end else begin
              wcnt <= wcnt + WAIT_W'(1);
            end
          end
        end
        T3: begin
          if (mid) begin
            ziorq_n <= 1'b1;
            zrd_n   <= 1'b1;
            zwr_n   <= 1'b1;
            if (rsp_err)  rsp_rdata <= 8'hFF;
            else if (!wr) rsp_rdata <= zd_in;
          end
          if (pre_last) rsp_valid <= 1'b1;
          if (last) begin
            zd_oe     <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_zbus_iomaster.sv
// Scoreboard bench for zbus_iomaster: stimulus pushes the expected response
// and cycle timing, a negedge monitor checks the bus cycle and the response.
module tb_zbus_iomaster;
  import zbus_pkg::*;

  logic        fclk = 1'b0;
  logic        zrst_n;
  logic        cmd_valid, cmd_ready, cmd_wr;
  logic [15:0] cmd_addr;
  logic [7:0]  cmd_wdata;
  logic        rsp_valid, rsp_ge, rsp_err;
  logic [7:0]  rsp_rdata;
  logic [15:0] za;
  logic [7:0]  zd_out, zd_in;
  logic        zd_oe, ziorq_n, zrd_n, zwr_n, zwait_n, ziorqge;

  zbus_iomaster #(.TDIV(4), .WAIT_MAX(15)) dut (
    .fclk(fclk), .zrst_n(zrst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_ge(rsp_ge), .rsp_err(rsp_err),
    .za(za), .zd_out(zd_out), .zd_oe(zd_oe), .zd_in(zd_in),
    .ziorq_n(ziorq_n), .zrd_n(zrd_n), .zwr_n(zwr_n),
    .zwait_n(zwait_n), .ziorqge(ziorqge)
  );

  always #5 fclk = ~fclk;

  typedef struct {
    bit          wr;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    bit          chk_rd;
    bit          ge;
    bit          err;
    int          vcyc;
    int          lo_last;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   b2b_arm = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  int   cyc = 0, acc_cyc = 0, rv_cyc = -100, k;
  int   lo_first, lo_last, oe_n;
  bit   active = 0, rdy_next = 0, za_ok, zd_ok, rd_lo, wr_lo, b2b_done = 0;
  exp_t e;

  always @(negedge fclk) begin
    cyc++;
    if (!zrst_n) begin
      active   = 0;
      rdy_next = 0;
    end else begin
      if (rdy_next) begin
        chk("ready_after_rsp", {31'd0, cmd_ready}, 32'd1);
        rdy_next = 0;
      end
      if (active && q.size() > 0) begin
        k = cyc - acc_cyc;
        e = q[0];
        if (za !== e.addr) za_ok = 0;
        if (e.wr && zd_out !== e.wdata) zd_ok = 0;
        if (!ziorq_n) begin
          if (lo_first < 0) lo_first = k;
          lo_last = k;
        end
        if (!zrd_n) rd_lo = 1;
        if (!zwr_n) wr_lo = 1;
        if (zd_oe) oe_n++;
        if (rsp_valid) begin
          void'(q.pop_front());
          chk("rsp_cycle", k, e.vcyc);
          chk("strobe_first", lo_first, 5);
          chk("strobe_last", lo_last, e.lo_last);
          chk("za_held", {31'd0, za_ok}, 32'd1);
          chk("zd_out_held", {31'd0, zd_ok}, 32'd1);
          chk("zrd_used", {31'd0, rd_lo}, {31'd0, !e.wr});
          chk("zwr_used", {31'd0, wr_lo}, {31'd0, e.wr});
          chk("zd_oe_cycles", oe_n, e.wr ? e.vcyc : 0);
          chk("rsp_ge", {31'd0, rsp_ge}, {31'd0, e.ge});
          chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
          if (e.chk_rd) chk("rsp_rdata", {24'd0, rsp_rdata}, {24'd0, e.rdata});
          active   = 0;
          rdy_next = 1;
          rv_cyc   = cyc;
        end
      end else if (rsp_valid) begin
        chk("unexpected_rsp", {31'd0, rsp_valid}, 32'd0);
      end
      if (cmd_valid && cmd_ready) begin
        if (b2b_arm && !b2b_done) begin
          chk("b2b_gap", cyc - rv_cyc, 1);
          b2b_done = 1;
        end
        active   = 1;
        acc_cyc  = cyc;
        lo_first = -1;
        lo_last  = -1;
        oe_n     = 0;
        za_ok    = 1;
        zd_ok    = 1;
        rd_lo    = 0;
        wr_lo    = 0;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic push(input bit wr, input logic [15:0] a, input logic [7:0] wd,
                      input logic [7:0] rd, input bit chk_rd, input bit ge,
                      input bit err, input int vcyc, input int lo_last_c);
    exp_t x;
    x.wr = wr; x.addr = a; x.wdata = wd; x.rdata = rd; x.chk_rd = chk_rd;
    x.ge = ge; x.err = err; x.vcyc = vcyc; x.lo_last = lo_last_c;
    q.push_back(x);
  endtask

  // Offer a command until accepted; returns 1 ns after the accepting edge.
  task automatic send(input bit wr, input logic [15:0] a, input logic [7:0] wd,
                      input bit drop_valid);
    int n = 0;
    @(posedge fclk); #1;
    cmd_wr = wr; cmd_addr = a; cmd_wdata = wd; cmd_valid = 1'b1;
    @(negedge fclk);
    while (!cmd_ready && n < 200) begin @(negedge fclk); n++; end
    if (!cmd_ready) chk("accept_timeout", {31'd0, cmd_ready}, 32'd1);
    @(posedge fclk); #1;
    if (drop_valid) begin
      cmd_valid = 1'b0;
      cmd_addr  = 16'hDEAD;
      cmd_wdata = 8'hEE;
      cmd_wr    = ~wr;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (q.size() != 0 && n < 300) begin @(negedge fclk); n++; end
    if (q.size() != 0) begin
      chk("rsp_timeout", q.size(), 0);
      q.delete();
    end
    repeat (2) @(negedge fclk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    zrst_n = 1'b0; cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = 16'h0;
    cmd_wdata = 8'h0; zd_in = 8'h0; zwait_n = 1'b1; ziorqge = 1'b0;

    repeat (3) @(negedge fclk);
    chk("rst_za", {16'd0, za}, 32'h0);
    chk("rst_zd_out", {24'd0, zd_out}, 32'h0);
    chk("rst_rdata", {24'd0, rsp_rdata}, 32'h0);
    chk("rst_flags", {25'd0, zd_oe, rsp_valid, rsp_ge, rsp_err, cmd_ready, 2'b00}, 32'h0);
    chk("rst_strobes", {29'd0, ziorq_n, zrd_n, zwr_n}, 32'h7);
    #1 zrst_n = 1'b1;
    #1 chk("ready_before_edge", {31'd0, cmd_ready}, 32'd0);
    @(posedge fclk); #1;
    chk("ready_after_release", {31'd0, cmd_ready}, 32'd1);

    // 1: plain write
    push(1, {8'h80, BASE_ADDR}, 8'h5A, 8'h00, 0, 0, 0, 16, 14);
    send(1, {8'h80, BASE_ADDR}, 8'h5A, 1);
    wait_idle();

    // 2: read with claim
    zd_in = 8'h3C; ziorqge = 1'b1;
    push(0, {8'h01, BASE_ADDR}, 8'h00, 8'h3C, 1, 1, 0, 16, 14);
    send(0, {8'h01, BASE_ADDR}, 8'h00, 1);
    wait_idle();
    ziorqge = 1'b0;

    // 3: read with two extra waits (TW samples at cycles 12 and 16 low)
    zd_in = 8'h77; zwait_n = 1'b0;
    push(0, {8'h02, BASE_ADDR}, 8'h00, 8'h77, 1, 0, 0, 24, 22);
    send(0, {8'h02, BASE_ADDR}, 8'h00, 1);
    repeat (17) @(posedge fclk);
    #1 zwait_n = 1'b1;
    wait_idle();

    // 4: wait timeout
    zd_in = 8'h11; zwait_n = 1'b0;
    push(0, {8'h03, BASE_ADDR}, 8'h00, 8'hFF, 1, 0, 1, 76, 74);
    send(0, {8'h03, BASE_ADDR}, 8'h00, 1);
    wait_idle();
    zwait_n = 1'b1;

    // 5: next command after timeout
    push(1, {8'h04, BASE_ADDR}, 8'hA5, 8'h00, 0, 0, 0, 16, 14);
    send(1, {8'h04, BASE_ADDR}, 8'hA5, 1);
    wait_idle();

    // 6: reset in cycle 7 of a write; no response expected
    send(1, {8'h07, BASE_ADDR}, 8'h66, 1);
    repeat (6) @(posedge fclk);
    #2 chk("pre_rst_zwr", {31'd0, zwr_n}, 32'd0);
    zrst_n = 1'b0;
    #1;
    chk("async_rst_strobes", {29'd0, ziorq_n, zrd_n, zwr_n}, 32'h7);
    chk("async_rst_zd_oe", {31'd0, zd_oe}, 32'd0);
    repeat (2) @(negedge fclk);
    #1 zrst_n = 1'b1;
    chk("rerst_ready_low", {31'd0, cmd_ready}, 32'd0);
    @(posedge fclk); #1;
    chk("rerst_ready_high", {31'd0, cmd_ready}, 32'd1);
    push(1, {8'h08, BASE_ADDR}, 8'h42, 8'h00, 0, 0, 0, 16, 14);
    send(1, {8'h08, BASE_ADDR}, 8'h42, 1);
    wait_idle();

    // 7: back-to-back, cmd_valid held high, cmd_* changed mid-cycle
    zd_in = 8'h9E;
    push(1, {8'h05, BASE_ADDR}, 8'hC3, 8'h00, 0, 0, 0, 16, 14);
    push(0, {8'h06, BASE_ADDR}, 8'h00, 8'h9E, 1, 0, 0, 16, 14);
    send(1, {8'h05, BASE_ADDR}, 8'hC3, 0);
    cmd_wr = 1'b0; cmd_addr = {8'h06, BASE_ADDR}; cmd_wdata = 8'h00;
    b2b_arm = 1;
    n = 0;
    @(negedge fclk);
    while (!cmd_ready && n < 200) begin @(negedge fclk); n++; end
    @(posedge fclk); #1 cmd_valid = 1'b0;
    wait_idle();
    chk("b2b_seen", {31'd0, b2b_done}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
